mac: RTL and testbench

MAC -- requirements
Module: mac

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_pe.sv | 22 ++
 rtl/mac.sv | 107 ++++++++++
 tb/tb_mac.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and constants for the 3x3 MAC pipeline
package mac_pkg;

    localparam int PIX_W  = 8;
    localparam int KER_W  = 4;
    localparam int ZP_W   = 9;
    localparam int Q_W    = 9;
    localparam int OUT_W  = 16;
    localparam int SUM_W  = 17;
    localparam int TAPS   = 9;

    // (pixel - zero_point) spans -511..255 (ZP_W+1 bits); times a 4-bit weight
    localparam int PROD_W = ZP_W + 1 + KER_W;

    // |S| * q before the rounding shift
    localparam int MUL_W  = SUM_W + Q_W;

    localparam logic [OUT_W-2:0] MAX_MAG = 15'd32767;

endpackage

// File: rtl/mac_pe.sv
// rtl/mac_pe.sv - one signed tap product (pixel - zero_point) * weight
//
// Ports:
//   pix  - unsigned pixel
//   zp   - unsigned pixel zero-point
//   ker  - two's-complement weight (-8..7)
//   prod - exact signed product
module mac_pe
    import mac_pkg::*;
(
    input  logic        [PIX_W-1:0]  pix,
    input  logic        [ZP_W-1:0]   zp,
    input  logic signed [KER_W-1:0]  ker,
    output logic signed [PROD_W-1:0] prod
);

    logic signed [ZP_W:0] diff;

    assign diff = $signed({2'b00, pix}) - $signed({1'b0, zp});
    assign prod = PROD_W'(diff) * PROD_W'(ker);

endmodule

// File: rtl/mac.sv
// rtl/mac.sv - 3-stage 3x3 multiply-accumulate with Q4 scaling and sign-magnitude output
//
// Ports:
//   clk, rstn           - clock, synchronous active-low reset
//   i_inhibit           - holds every pipeline register, masks o_valid
//   i_valid             - current window valid
//   i_q                 - unsigned output scale, Q4 (16 = 1.0)
//   zero_vector         - unsigned pixel zero-point
//   i_im1..i_im9        - unsigned pixels, row-major
//   i_ker1..i_ker9      - two's-complement weights, same order
//   o_valid, o_conv     - result strobe and sign-magnitude result
//   o_transistor_num    - TRANS_EST when MAC_TRANSISTOR_COUNT_EN is defined, else 0
module mac
    import mac_pkg::*;
#(
    parameter logic [50:0] TRANS_EST = 51'd120000
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_inhibit,
    input  logic             i_valid,
    input  logic [Q_W-1:0]   i_q,
    input  logic [ZP_W-1:0]  zero_vector,
    input  logic [PIX_W-1:0] i_im1, i_im2, i_im3, i_im4, i_im5, i_im6, i_im7, i_im8, i_im9,
    input  logic [KER_W-1:0] i_ker1, i_ker2, i_ker3, i_ker4, i_ker5, i_ker6, i_ker7, i_ker8, i_ker9,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_conv,
    output logic [50:0]      o_transistor_num
);

    logic        [PIX_W-1:0]  im      [TAPS];
    logic signed [KER_W-1:0]  ker     [TAPS];
    logic signed [PROD_W-1:0] prod_c  [TAPS];
    logic signed [PROD_W-1:0] prod_q  [TAPS];

    logic                     v1, v2, v3;
    logic        [Q_W-1:0]    q1, q2;
    logic signed [SUM_W-1:0]  sum_c, sum_q;
    logic        [SUM_W-1:0]  abs_s;
    logic        [MUL_W-1:0]  scaled, shifted;
    logic        [OUT_W-2:0]  mag;
    logic        [OUT_W-1:0]  conv_c, conv_q;

    assign im  = '{i_im1, i_im2, i_im3, i_im4, i_im5, i_im6, i_im7, i_im8, i_im9};
    assign ker = '{i_ker1, i_ker2, i_ker3, i_ker4, i_ker5, i_ker6, i_ker7, i_ker8, i_ker9};

    for (genvar k = 0; k < TAPS; k++) begin : g_pe
        mac_pe u_pe (
            .pix  (im[k]),
            .zp   (zero_vector),
            .ker  (ker[k]),
            .prod (prod_c[k])
        );
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_c = sum_c + {{(SUM_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
        end
    end

    // Scale travels with its window so a q change never mixes with older data.
    always_comb begin
        abs_s   = sum_q[SUM_W-1] ? -sum_q : sum_q;
        scaled  = {{Q_W{1'b0}}, abs_s} * {{SUM_W{1'b0}}, q2};
        shifted = (scaled + MUL_W'(8)) >> 4;
        mag     = (shifted > MUL_W'(MAX_MAG)) ? MAX_MAG : shifted[OUT_W-2:0];
        // Sign only when the rounded magnitude survives: no negative zero.
        conv_c  = {sum_q[SUM_W-1] && (mag != '0), mag};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            q1     <= '0;
            q2     <= '0;
            sum_q  <= '0;
            conv_q <= '0;
            for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
        end else if (!i_inhibit) begin
            v1     <= i_valid;
            q1     <= i_q;
            for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_c[k];
            v2     <= v1;
            q2     <= q1;
            sum_q  <= sum_c;
            v3     <= v2;
            // Only valid windows update the output, so it holds between results.
            if (v2) conv_q <= conv_c;
        end
    end

    assign o_valid = v3 && !i_inhibit;
    assign o_conv  = conv_q;

`ifdef MAC_TRANSISTOR_COUNT_EN
    assign o_transistor_num = TRANS_EST;
`else
    // Masked to zero; the parameter stays referenced in both builds.
    assign o_transistor_num = TRANS_EST & 51'd0;
`endif

endmodule

// File: tb/tb_mac.sv
// tb/tb_mac.sv - directed vector bench for the 3x3 MAC pipeline
module tb_mac;

    typedef struct packed {
        logic [71:0] im;
        logic [35:0] ker;
        logic [8:0]  zv;
        logic [8:0]  q;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn, i_inhibit, i_valid;
    logic [8:0]  i_q, zero_vector;
    logic [7:0]  i_im1, i_im2, i_im3, i_im4, i_im5, i_im6, i_im7, i_im8, i_im9;
    logic [3:0]  i_ker1, i_ker2, i_ker3, i_ker4, i_ker5, i_ker6, i_ker7, i_ker8, i_ker9;
    logic        o_valid;
    logic [15:0] o_conv;
    logic [50:0] o_transistor_num;

    int nvec = 0;
    int nbad = 0;

    vec_t        tbl [15];
    vec_t        sw  [126];
    logic [15:0] sexp[126];

    mac dut (
        .clk(clk), .rstn(rstn), .i_inhibit(i_inhibit), .i_valid(i_valid),
        .i_q(i_q), .zero_vector(zero_vector),
        .i_im1(i_im1), .i_im2(i_im2), .i_im3(i_im3), .i_im4(i_im4), .i_im5(i_im5),
        .i_im6(i_im6), .i_im7(i_im7), .i_im8(i_im8), .i_im9(i_im9),
        .i_ker1(i_ker1), .i_ker2(i_ker2), .i_ker3(i_ker3), .i_ker4(i_ker4), .i_ker5(i_ker5),
        .i_ker6(i_ker6), .i_ker7(i_ker7), .i_ker8(i_ker8), .i_ker9(i_ker9),
        .o_valid(o_valid), .o_conv(o_conv), .o_transistor_num(o_transistor_num)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] rep8(input logic [7:0] x);
        return {9{x}};
    endfunction

    function automatic logic [35:0] rep4(input logic [3:0] x);
        return {9{x}};
    endfunction

    function automatic vec_t mk(input logic [71:0] im, input logic [35:0] ker,
                                input logic [8:0] zv, input logic [8:0] q, input logic [15:0] e);
        vec_t v;
        v.im = im; v.ker = ker; v.zv = zv; v.q = q; v.exp = e;
        return v;
    endfunction

    // Integer reference for the stream test.
    function automatic logic [15:0] model(input vec_t v);
        int s, a, m;
        logic [3:0] kb;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            kb = v.ker[k*4 +: 4];
            s += (int'(v.im[k*8 +: 8]) - int'(v.zv)) * int'($signed(kb));
        end
        a = (s < 0) ? -s : s;
        m = (a * int'(v.q) + 8) / 16;
        if (m > 32767) m = 32767;
        return {(s < 0) && (m != 0), 15'(m)};
    endfunction

    task automatic drive(input vec_t v, input logic vld);
        i_im1 = v.im[7:0];   i_im2 = v.im[15:8];  i_im3 = v.im[23:16];
        i_im4 = v.im[31:24]; i_im5 = v.im[39:32]; i_im6 = v.im[47:40];
        i_im7 = v.im[55:48]; i_im8 = v.im[63:56]; i_im9 = v.im[71:64];
        i_ker1 = v.ker[3:0];   i_ker2 = v.ker[7:4];   i_ker3 = v.ker[11:8];
        i_ker4 = v.ker[15:12]; i_ker5 = v.ker[19:16]; i_ker6 = v.ker[23:20];
        i_ker7 = v.ker[27:24]; i_ker8 = v.ker[31:28]; i_ker9 = v.ker[35:32];
        zero_vector = v.zv;
        i_q         = v.q;
        i_valid     = vld;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    initial begin
        logic [2:0]  vseen;
        logic [50:0] tn_exp;
        logic        stale;
        int          rx;

        tbl[0]  = mk(rep8(8'd1),   rep4(4'h1), 9'd0,   9'd16,  16'h0009);
        tbl[1]  = mk(rep8(8'd1),   rep4(4'h1), 9'd0,   9'd17,  16'h000A);
        tbl[2]  = mk(rep8(8'd10),  rep4(4'hF), 9'd0,   9'd16,  16'h805A);
        tbl[3]  = mk(rep8(8'd0),   rep4(4'h8), 9'd511, 9'd16,  16'h7FFF);
        tbl[4]  = mk(rep8(8'd5),   rep4(4'h7), 9'd5,   9'd16,  16'h0000);
        tbl[5]  = mk(rep8(8'd1),   rep4(4'h1), 9'd0,   9'd0,   16'h0000);
        tbl[6]  = mk(rep8(8'd1),   rep4(4'h1), 9'd0,   9'd1,   16'h0001);
        tbl[7]  = mk(rep8(8'd1),   {32'h0, 4'h9}, 9'd0, 9'd1,  16'h0000);
        tbl[8]  = mk({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                     {4'h7, 4'hC, 4'h4, 4'hD, 4'h3, 4'hE, 4'h2, 4'hF, 4'h1},
                     9'd0, 9'd16, 16'h0035);
        tbl[9]  = mk({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                     {4'h7, 4'hC, 4'h4, 4'hD, 4'h3, 4'hE, 4'h2, 4'hF, 4'h1},
                     9'd5, 9'd16, 16'h0012);
        tbl[10] = mk(rep8(8'd10),  rep4(4'hF), 9'd0,   9'd24,  16'h8087);
        tbl[11] = mk(rep8(8'd10),  rep4(4'hF), 9'd0,   9'd511, 16'h8B3A);
        tbl[12] = mk(rep8(8'd1),   {32'h0, 4'h1}, 9'd0, 9'd8,  16'h0001);
        tbl[13] = mk(rep8(8'd1),   {32'h0, 4'h1}, 9'd0, 9'd7,  16'h0000);
        tbl[14] = mk(rep8(8'd255), rep4(4'h8), 9'd0,   9'd32,  16'hFFFF);

        for (int i = 0; i < 126; i++) begin
            sw[i].im  = {$urandom, $urandom, $urandom};
            sw[i].ker = {$urandom, $urandom};
            sw[i].zv  = 9'($urandom_range(0, 511));
            sw[i].q   = 9'($urandom_range(0, 511));
            sw[i].exp = 16'h0;
            sexp[i]   = model(sw[i]);
        end

        // Reset state
        rstn = 1'b0;
        i_inhibit = 1'b0;
        drive(tbl[0], 1'b0);
        repeat (3) @(posedge clk);
        #1;
`ifdef MAC_TRANSISTOR_COUNT_EN
        tn_exp = 51'd120000;
`else
        tn_exp = 51'd0;
`endif
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_conv", 64'(o_conv), 64'h0);
        chk("transistor_num_in_reset", 64'(o_transistor_num), 64'(tn_exp));
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single windows: exact 3-cycle latency, value, and hold afterwards
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i], 1'b1);
            @(posedge clk); #1;
            drive(tbl[i], 1'b0);
            vseen[0] = o_valid;
            @(posedge clk); #1;
            vseen[1] = o_valid;
            @(posedge clk); #1;
            vseen[2] = o_valid;
            chk($sformatf("latency_v%0d", i), 64'(vseen), 64'b100);
            chk($sformatf("conv_v%0d", i), 64'(o_conv), 64'(tbl[i].exp));
            @(posedge clk); #1;
            chk($sformatf("hold_v%0d", i), 64'({o_valid, o_conv}), 64'({1'b0, tbl[i].exp}));
        end

        // 126-window back-to-back stream with a 5-cycle inhibit in the middle
        rx = 0;
        fork
            begin
                int idx = 0;
                for (int c = 0; idx < 126 && c < 400; c++) begin
                    i_inhibit = (c >= 40 && c < 45);
                    drive(sw[idx], 1'b1);
                    @(posedge clk); #1;
                    if (!i_inhibit) idx++;
                end
                i_inhibit = 1'b0;
                i_valid   = 1'b0;
            end
            begin
                int cyc = 0;
                while (rx < 126 && cyc < 600) begin
                    @(negedge clk);
                    cyc++;
                    if (i_inhibit) chk($sformatf("inhibit_valid_c%0d", cyc), 64'(o_valid), 64'd0);
                    if (o_valid) begin
                        chk($sformatf("stream_%0d", rx), 64'(o_conv), 64'(sexp[rx]));
                        rx++;
                    end
                end
            end
        join
        chk("stream_count", 64'(rx), 64'd126);
        stale = 1'b0;
        repeat (4) begin
            @(negedge clk);
            stale |= o_valid;
        end
        chk("stream_no_extra", 64'(stale), 64'd0);

        // Mid-stream reset discards in-flight windows
        @(posedge clk); #1;
        drive(tbl[0], 1'b1);
        @(posedge clk); #1;
        drive(tbl[0], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_conv", 64'({o_valid, o_conv}), 64'({1'b1, 16'h0009}));
        drive(tbl[2], 1'b1);
        @(posedge clk); #1;
        drive(tbl[1], 1'b1);
        @(posedge clk); #1;
        rstn = 1'b0;
        i_valid = 1'b0;
        @(posedge clk); #1;
        chk("reset_mid_valid", 64'(o_valid), 64'd0);
        chk("reset_mid_conv", 64'(o_conv), 64'h0);
        rstn = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            stale |= o_valid;
        end
        chk("reset_no_stale", 64'(stale), 64'd0);
        chk("transistor_num", 64'(o_transistor_num), 64'(tn_exp));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
